async_fifo_wr_adapter: RTL and testbench

Write-domain front end for the team's small dual-clock FIFO. It converts an upstream valid/ready stream with an end-of-packet marker into the FIFO's write-side signals (wdata/winc), with backpressure taken from wfull and w_almost_full. A 2-entry skid buffer keeps s_ready registered. A packet-atomic state machine starts a new packet only when the FIFO is not almost full. It also keeps write-side statistics: a packet counter and a stall counter.

---
 rtl/async_fifo_wr_pkg.sv | 37 +++
 rtl/async_fifo_wr_adapter_skid.sv | 108 ++++++++++
 rtl/async_fifo_wr_adapter.sv | 155 +++++++++++++++
 tb/tb_async_fifo_wr_adapter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/async_fifo_wr_pkg.sv
// ---------------------------------------------------------------------------
// async_fifo_wr_pkg
//   Shared types and helpers for the write-domain front end of the dual-clock
//   FIFO (async_fifo_wr_adapter and its skid buffer).
//
//   Contents:
//     wr_state_e   packet state: IDLE (between packets) / IN_PKT
//     SKID_DEPTH   number of entries in the skid buffer
//     SKID_CNT_W   width of the skid buffer occupancy count (0..SKID_DEPTH)
//     MAX_DSIZE    widest payload the packing helper supports
//     pack_word()  builds the FIFO word {last, data} for a payload of width
//                  dsize; the caller keeps bits [dsize:0] of the result
// ---------------------------------------------------------------------------
package async_fifo_wr_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } wr_state_e;

  localparam int SKID_DEPTH = 2;
  localparam int SKID_CNT_W = $clog2(SKID_DEPTH + 1);
  localparam int MAX_DSIZE  = 64;

  // data must already be zero-extended to MAX_DSIZE bits; last lands at bit
  // position dsize, directly above the payload.
  function automatic logic [MAX_DSIZE:0] pack_word(
    input logic                 last,
    input logic [MAX_DSIZE-1:0] data,
    input int                   dsize
  );
    logic [MAX_DSIZE:0] word;
    word = {1'b0, data} | ((MAX_DSIZE + 1)'(last) << dsize);
    return word;
  endfunction

endpackage

// File: rtl/async_fifo_wr_adapter_skid.sv
// ---------------------------------------------------------------------------
// wr_skid_buf
//   Small FIFO-ordered skid buffer (SKID_DEPTH entries) sitting between the
//   upstream valid/ready stream and the FIFO write port. The ready output is
//   a register computed from the next occupancy, so an accepted word always
//   has a free slot and upstream never sees a combinational path from pop.
//
//   Ports:
//     wclk        write-domain clock
//     wrst_n      asynchronous active-low reset
//     push_valid  upstream word valid (push happens when push_valid && ready)
//     push_data   word to store at the tail
//     ready       registered "space available", 0 during and right after reset
//     pop         consume the head entry this cycle (ignored when empty)
//     head_data   oldest entry, forced to 0 when the buffer is empty
//     count       current occupancy
// ---------------------------------------------------------------------------
module wr_skid_buf
  import async_fifo_wr_pkg::*;
#(
  parameter int WIDTH = 9
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic                  push_valid,
  input  logic [WIDTH-1:0]      push_data,
  output logic                  ready,
  input  logic                  pop,
  output logic [WIDTH-1:0]      head_data,
  output logic [SKID_CNT_W-1:0] count
);

  localparam int PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam logic [SKID_CNT_W-1:0] DEPTH_C = SKID_CNT_W'(SKID_DEPTH);

  logic [WIDTH-1:0]      mem_reg [SKID_DEPTH];
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [SKID_CNT_W-1:0] count_reg;
  logic [SKID_CNT_W-1:0] count_next;
  logic                  ready_reg;
  logic                  do_push;
  logic                  do_pop;
  logic [SKID_DEPTH-1:0] entry_we;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(SKID_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_push = push_valid && ready_reg;
  // Popping an empty buffer is dropped here so the occupancy can never wrap.
  assign do_pop  = pop && (count_reg != '0);

  genvar gi;
  generate
    for (gi = 0; gi < SKID_DEPTH; gi++) begin : g_entry_we
      assign entry_we[gi] = do_push && (wr_ptr_reg == PTR_W'(gi));
    end
  endgenerate

  always_comb begin
    count_next = count_reg;
    if (do_push && !do_pop) begin
      count_next = count_reg + SKID_CNT_W'(1);
    end else if (!do_push && do_pop) begin
      count_next = count_reg - SKID_CNT_W'(1);
    end
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      for (int i = 0; i < SKID_DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < SKID_DEPTH; i++) begin
        if (entry_we[i]) begin
          mem_reg[i] <= push_data;
        end
      end
    end
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      ready_reg  <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      end
      if (do_pop) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
      count_reg <= count_next;
      // Looking at the next occupancy keeps ready registered while still
      // guaranteeing room for whatever is accepted on the following edge.
      ready_reg <= (count_next < DEPTH_C);
    end
  end

  assign ready     = ready_reg;
  assign count     = count_reg;
  assign head_data = (count_reg != '0) ? mem_reg[rd_ptr_reg] : '0;

endmodule

// File: rtl/async_fifo_wr_adapter.sv
// ---------------------------------------------------------------------------
// async_fifo_wr_adapter
//   Write-domain front end for the dual-clock FIFO. Converts an upstream
//   valid/ready stream with an end-of-packet marker into FIFO wdata/winc,
//   taking backpressure from wfull and w_almost_full. A new packet is only
//   started while the FIFO is not almost full; with PKT_ATOMIC=1 a packet
//   already in flight is allowed to finish into the FIFO's headroom.
//   Also keeps a wrapping packet counter and a saturating stall counter.
//
//   Parameters:
//     DSIZE       payload width; FIFO word is DSIZE+1 bits, bit DSIZE = last
//     CNT_W       width of pkt_count / stall_count
//     PKT_ATOMIC  1: almost-full gates packet starts only; 0: every word
//
//   Ports:
//     wclk, wrst_n        write clock, async active-low reset (shared with
//                         the FIFO write side)
//     s_data/s_last/
//     s_valid/s_ready     upstream stream; s_ready is registered
//     fifo_wdata          {last, data} of the head word, 0 when empty
//     fifo_winc           FIFO write strobe
//     fifo_wfull          FIFO full, hard stop for writes
//     fifo_w_almost_full  FIFO almost full, packet-start gating
//     pkt_count           packets written (wraps)
//     stall_count         cycles with buffered data but no write (saturates)
// ---------------------------------------------------------------------------
module async_fifo_wr_adapter
  import async_fifo_wr_pkg::*;
#(
  parameter int DSIZE      = 8,
  parameter int CNT_W      = 16,
  parameter bit PKT_ATOMIC = 1'b1
) (
  input  logic             wclk,
  input  logic             wrst_n,
  input  logic [DSIZE-1:0] s_data,
  input  logic             s_last,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [DSIZE:0]   fifo_wdata,
  output logic             fifo_winc,
  input  logic             fifo_wfull,
  input  logic             fifo_w_almost_full,
  output logic [CNT_W-1:0] pkt_count,
  output logic [CNT_W-1:0] stall_count
);

  logic [MAX_DSIZE:0]    packed_full;
  logic [DSIZE:0]        push_word;
  logic [DSIZE:0]        head_word;
  logic [SKID_CNT_W-1:0] skid_count;
  logic                  buf_nonempty;
  logic                  head_last;
  logic                  can_write;
  wr_state_e             state_reg;
  logic [CNT_W-1:0]      pkt_count_reg;
  logic [CNT_W-1:0]      stall_count_reg;

  // -------------------------------------------------------------------------
  // Word packing: {last, data} is formed once at the input so the buffer and
  // the FIFO both see the same word layout.
  // -------------------------------------------------------------------------
  assign packed_full = pack_word(s_last, MAX_DSIZE'(s_data), DSIZE);
  assign push_word   = packed_full[DSIZE:0];

  generate
    if (DSIZE < MAX_DSIZE) begin : g_pack_tail
      logic unused_pack_bits;
      assign unused_pack_bits = ^packed_full[MAX_DSIZE:DSIZE+1];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Skid buffer
  // -------------------------------------------------------------------------
  wr_skid_buf #(
    .WIDTH (DSIZE + 1)
  ) u_skid (
    .wclk       (wclk),
    .wrst_n     (wrst_n),
    .push_valid (s_valid),
    .push_data  (push_word),
    .ready      (s_ready),
    .pop        (can_write),
    .head_data  (head_word),
    .count      (skid_count)
  );

  assign buf_nonempty = (skid_count != '0);
  assign head_last    = head_word[DSIZE];

  // -------------------------------------------------------------------------
  // Write gating. Only registered state and FIFO status feed this, never
  // s_valid, so the strobe has no combinational path from upstream. wfull is
  // checked in every state; the FIFO is never trusted to ignore winc.
  // -------------------------------------------------------------------------
  always_comb begin
    can_write = 1'b0;
    if (buf_nonempty && !fifo_wfull) begin
      if (state_reg == IDLE) begin
        can_write = !fifo_w_almost_full;
      end else begin
        can_write = PKT_ATOMIC || !fifo_w_almost_full;
      end
    end
  end

  assign fifo_winc  = can_write;
  assign fifo_wdata = head_word;

  // -------------------------------------------------------------------------
  // Packet state: tracks whether the next word written is a packet start.
  // A single-word packet (last on the first word) leaves the state in IDLE.
  // -------------------------------------------------------------------------
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_reg <= IDLE;
    end else if (can_write) begin
      case (state_reg)
        IDLE: begin
          if (!head_last) begin
            state_reg <= IN_PKT;
          end
        end
        IN_PKT: begin
          if (head_last) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Statistics
  // -------------------------------------------------------------------------
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      pkt_count_reg   <= '0;
      stall_count_reg <= '0;
    end else begin
      if (can_write && head_last) begin
        pkt_count_reg <= pkt_count_reg + CNT_W'(1);
      end
      if (buf_nonempty && !can_write && (stall_count_reg != '1)) begin
        stall_count_reg <= stall_count_reg + CNT_W'(1);
      end
    end
  end

  assign pkt_count   = pkt_count_reg;
  assign stall_count = stall_count_reg;

endmodule

// File: tb/tb_async_fifo_wr_adapter.sv
module tb_async_fifo_wr_adapter;
  import async_fifo_wr_pkg::*;

  localparam int DSIZE = 8;
  localparam int CNT_W = 16;

  logic wclk = 1'b0;
  always #5 wclk = ~wclk;

  logic             wrst_n = 1'b0;
  logic [DSIZE-1:0] s_data = '0;
  logic             s_last = 1'b0;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [DSIZE:0]   fifo_wdata;
  logic             fifo_winc;
  logic             fifo_wfull = 1'b0;
  logic             fifo_w_almost_full = 1'b0;
  logic [CNT_W-1:0] pkt_count;
  logic [CNT_W-1:0] stall_count;

  // Second instance with per-word almost-full gating
  logic [DSIZE-1:0] a_data = '0;
  logic             a_last = 1'b0;
  logic             a_valid = 1'b0;
  logic             a_ready;
  logic [DSIZE:0]   a_wdata;
  logic             a_winc;
  logic             a_wfull = 1'b0;
  logic             a_af = 1'b0;
  logic [CNT_W-1:0] a_pkt;
  logic [CNT_W-1:0] a_stall;

  async_fifo_wr_adapter #(.DSIZE(DSIZE), .CNT_W(CNT_W), .PKT_ATOMIC(1'b1)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .s_data(s_data), .s_last(s_last),
    .s_valid(s_valid), .s_ready(s_ready), .fifo_wdata(fifo_wdata),
    .fifo_winc(fifo_winc), .fifo_wfull(fifo_wfull),
    .fifo_w_almost_full(fifo_w_almost_full), .pkt_count(pkt_count),
    .stall_count(stall_count)
  );

  async_fifo_wr_adapter #(.DSIZE(DSIZE), .CNT_W(CNT_W), .PKT_ATOMIC(1'b0)) dut0 (
    .wclk(wclk), .wrst_n(wrst_n), .s_data(a_data), .s_last(a_last),
    .s_valid(a_valid), .s_ready(a_ready), .fifo_wdata(a_wdata),
    .fifo_winc(a_winc), .fifo_wfull(a_wfull),
    .fifo_w_almost_full(a_af), .pkt_count(a_pkt),
    .stall_count(a_stall)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int acc_count = 0;
  logic [DSIZE:0] tx_q[$];
  logic [DSIZE:0] exp_q[$];
  int wr_cyc_q[$];
  int acc_cyc_q[$];

  always @(posedge wclk) cyc <= cyc + 1;

  function automatic logic [DSIZE:0] w(input logic last, input logic [DSIZE-1:0] d);
    return {last, d};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_word(input logic last, input logic [DSIZE-1:0] d);
    tx_q.push_back(w(last, d));
    exp_q.push_back(w(last, d));
  endtask

  // Driver: presents the head of tx_q, retires it when accepted.
  logic accept_pending;
  always begin
    @(negedge wclk);
    accept_pending = s_valid && s_ready;
    @(posedge wclk);
    #1;
    if (accept_pending && tx_q.size() != 0) begin
      void'(tx_q.pop_front());
      acc_cyc_q.push_back(cyc);
      acc_count++;
    end
    if (tx_q.size() != 0) begin
      s_valid = 1'b1;
      {s_last, s_data} = tx_q[0];
    end else begin
      s_valid = 1'b0;
    end
  end

  // Monitor: every FIFO write is checked against the scoreboard.
  always @(negedge wclk) begin
    if (fifo_winc === 1'b1) begin
      wr_cyc_q.push_back(cyc);
      check("no_write_while_wfull", int'(fifo_wfull), 0);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpected_write: got 0x%0h, expected no write (cycle %0d)", fifo_wdata, cyc);
      end else begin
        logic [DSIZE:0] e;
        e = exp_q.pop_front();
        $display("[TB] write cycle %0d data 0x%0h", cyc, fifo_wdata);
        check("wdata", int'(fifo_wdata), int'(e));
      end
    end
  end

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((tx_q.size() != 0 || exp_q.size() != 0) && n < 300) begin
      @(negedge wclk);
      n++;
    end
    check(name, int'(n < 300), 1);
    @(posedge wclk);
    @(negedge wclk);
  endtask

  task automatic wait_write_of(input string name, input logic [DSIZE:0] word);
    int n;
    bit found;
    n = 0;
    found = 0;
    while (!found && n < 100) begin
      @(negedge wclk);
      n++;
      if (fifo_winc && fifo_wdata == word) found = 1;
    end
    check(name, int'(found), 1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;

    // ---- 1: reset with s_valid asserted, then 2: 8-word stream ----
    for (int i = 0; i < 8; i++) push_word(i == 7, DSIZE'(i));
    for (int i = 0; i < 3; i++) begin
      @(posedge wclk);
      @(negedge wclk);
      check("rst_s_ready", int'(s_ready), 0);
      check("rst_winc", int'(fifo_winc), 0);
      check("rst_wdata", int'(fifo_wdata), 0);
      check("rst_pkt_count", int'(pkt_count), 0);
      check("rst_stall_count", int'(stall_count), 0);
    end
    wrst_n = 1'b1;
    @(negedge wclk);
    check("first_edge_ready", int'(s_ready), 1);
    check("first_edge_winc", int'(fifo_winc), 0);
    wait_idle("t2_drain");
    check("t2_accepts", acc_cyc_q.size(), 8);
    check("t2_writes", wr_cyc_q.size(), 8);
    if (acc_cyc_q.size() > 0) begin
      for (int i = 0; i < wr_cyc_q.size(); i++)
        check("t2_write_cycle", wr_cyc_q[i], acc_cyc_q[0] + i);
    end
    check("t2_pkt_count", int'(pkt_count), 1);
    check("t2_stall_count", int'(stall_count), 0);

    // ---- 3: wfull for 4 cycles after word 0x13 is written ----
    wr_cyc_q.delete();
    for (int i = 0; i < 8; i++) push_word(i == 7, DSIZE'(8'h10 + i));
    wait_write_of("t3_saw_0x13", w(1'b0, 8'h13));
    @(posedge wclk); #1;
    fifo_wfull = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge wclk);
      check("t3_winc_during_wfull", int'(fifo_winc), 0);
    end
    check("t3_s_ready_low", int'(s_ready), 0);
    @(posedge wclk); #1;
    fifo_wfull = 1'b0;
    wait_idle("t3_drain");
    check("t3_writes", wr_cyc_q.size(), 8);
    check("t3_pkt_count", int'(pkt_count), 2);
    check("t3_stall_count", int'(stall_count), 4);

    // ---- 4a: almost full in IDLE blocks a packet start ----
    @(posedge wclk); #1;
    fifo_w_almost_full = 1'b1;
    push_word(1'b1, 8'h20);
    for (int k = 0; k < 6; k++) begin
      @(negedge wclk);
      check("t4a_winc_af_idle", int'(fifo_winc), 0);
    end
    check("t4a_word_held", exp_q.size(), 1);
    check("t4a_head", int'(fifo_wdata), int'(w(1'b1, 8'h20)));
    @(posedge wclk); #1;
    fifo_w_almost_full = 1'b0;
    wait_idle("t4a_drain");
    check("t4a_pkt_count", int'(pkt_count), 3);

    // ---- 4b: almost full mid-packet, packet completes, next one waits ----
    push_word(1'b0, 8'h30);
    push_word(1'b0, 8'h31);
    push_word(1'b0, 8'h32);
    push_word(1'b1, 8'h33);
    push_word(1'b1, 8'h34);
    wait_write_of("t4b_saw_0x30", w(1'b0, 8'h30));
    @(posedge wclk); #1;
    fifo_w_almost_full = 1'b1;
    repeat (8) @(negedge wclk);
    check("t4b_next_pkt_held", exp_q.size(), 1);
    check("t4b_head", int'(fifo_wdata), int'(w(1'b1, 8'h34)));
    check("t4b_winc", int'(fifo_winc), 0);
    check("t4b_pkt_count", int'(pkt_count), 4);
    check("t4b_state", int'(dut.state_reg), int'(IDLE));
    @(posedge wclk); #1;
    fifo_w_almost_full = 1'b0;
    wait_idle("t4b_drain");
    check("t4b_pkt_count_end", int'(pkt_count), 5);

    // ---- 4c: PKT_ATOMIC=0 stops immediately mid-packet ----
    @(posedge wclk); #1;
    a_valid = 1'b1; a_data = 8'h40; a_last = 1'b0;
    @(negedge wclk);
    check("t4c_ready", int'(a_ready), 1);
    @(posedge wclk); #1;
    a_data = 8'h41; a_last = 1'b1;
    @(negedge wclk);
    check("t4c_first_winc", int'(a_winc), 1);
    check("t4c_first_data", int'(a_wdata), int'(w(1'b0, 8'h40)));
    @(posedge wclk); #1;
    a_valid = 1'b0;
    a_af = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge wclk);
      check("t4c_winc_af_in_pkt", int'(a_winc), 0);
    end
    check("t4c_head", int'(a_wdata), int'(w(1'b1, 8'h41)));
    @(posedge wclk); #1;
    a_af = 1'b0;
    @(negedge wclk);
    check("t4c_resume_winc", int'(a_winc), 1);
    @(posedge wclk);
    @(negedge wclk);
    check("t4c_pkt_count", int'(a_pkt), 1);
    check("t4c_stall_count", int'(a_stall), 3);
    check("t4c_idle_winc", int'(a_winc), 0);

    // ---- 5: single-word packets keep the state in IDLE ----
    push_word(1'b1, 8'h50);
    push_word(1'b1, 8'h51);
    push_word(1'b1, 8'h52);
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge wclk);
      n++;
      check("t5_state_idle", int'(dut.state_reg), int'(IDLE));
    end
    check("t5_drain", int'(n < 100), 1);
    @(posedge wclk);
    @(negedge wclk);
    check("t5_pkt_count", int'(pkt_count), 8);
    check("t5_state_end", int'(dut.state_reg), int'(IDLE));

    // ---- 6: reset after 2 of 5 words accepted ----
    base = acc_count;
    for (int i = 0; i < 5; i++) push_word(i == 4, DSIZE'(8'h60 + i));
    n = 0;
    while (acc_count < base + 2 && n < 50) begin
      @(posedge wclk); #2;
      n++;
    end
    check("t6_two_accepted", int'(n < 50), 1);
    wrst_n = 1'b0;
    tx_q.delete();
    exp_q.delete();
    for (int k = 0; k < 2; k++) begin
      @(negedge wclk);
      check("t6_rst_s_ready", int'(s_ready), 0);
      check("t6_rst_winc", int'(fifo_winc), 0);
      check("t6_rst_wdata", int'(fifo_wdata), 0);
      check("t6_rst_skid_count", int'(dut.skid_count), 0);
      check("t6_rst_state", int'(dut.state_reg), int'(IDLE));
      check("t6_rst_pkt_count", int'(pkt_count), 0);
      check("t6_rst_stall_count", int'(stall_count), 0);
    end
    wrst_n = 1'b1;
    push_word(1'b0, 8'h70);
    push_word(1'b0, 8'h71);
    push_word(1'b1, 8'h72);
    wait_idle("t6_drain");
    check("t6_pkt_count", int'(pkt_count), 1);
    check("t6_stall_count", int'(stall_count), 0);
    check("t6_state", int'(dut.state_reg), int'(IDLE));

    repeat (2) @(negedge wclk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
